// File: rtl/traffic_pkg.sv
// Shared types and pure helpers for the adaptive phase controller.
// These cover the state/lamp encodings, green sizing and the round-robin phase search.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_GREEN,
    ST_YELLOW,
    ST_ALL_RED,
    ST_PED_WALK,
    ST_EMERG_GREEN
  } state_t;

  typedef enum logic [1:0] {
    LAMP_RED,
    LAMP_YELLOW,
    LAMP_GREEN
  } lamp_t;

  localparam int unsigned MAX_PHASES = 32;

  function automatic lamp_t lamp_of(state_t s);
    case (s)
      ST_GREEN, ST_EMERG_GREEN: lamp_of = LAMP_GREEN;
      ST_YELLOW:                lamp_of = LAMP_YELLOW;
      default:                  lamp_of = LAMP_RED;
    endcase
  endfunction

  // Evaluated at 32 bits so the sum cannot wrap before it is clamped.
  function automatic int unsigned sat_green(int unsigned cnt, int unsigned min_g,
                                            int unsigned step, int unsigned max_g);
    int unsigned d;
    d = min_g + cnt * step;
    return (d > max_g) ? max_g : d;
  endfunction

  // First phase after cur (mod n) whose bit is set in busy; cur+1 when none is busy.
  function automatic int unsigned next_phase(int unsigned cur, logic [MAX_PHASES-1:0] busy,
                                             int unsigned n);
    int unsigned p;
    logic        found;
    found      = 1'b0;
    next_phase = (cur + 1 >= n) ? 0 : cur + 1;
    for (int unsigned k = 1; k <= MAX_PHASES; k++) begin
      p = cur + k;
      if (p >= n) p = p - n;
      if (!found && k <= n && busy[p[4:0]]) begin
        next_phase = p;
        found      = 1'b1;
      end
    end
  endfunction

  function automatic int unsigned lowest_set(logic [MAX_PHASES-1:0] v);
    lowest_set = 0;
    for (int i = MAX_PHASES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 32'(i);
    end
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state duration counter: loads on state entry, counts seconds down to 0.
// done fires on the tick that consumes the last second; a count of 0 stays frozen.
module phase_timer #(
  parameter int TIME_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              tick,
  output logic [TIME_W-1:0] count,
  output logic              done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - TIME_W'(1);
    end
  end

  assign done = tick && (count == TIME_W'(1));

endmodule

// File: rtl/adaptive_phase_controller.sv
// N-phase demand-adaptive intersection controller with latched ped walk and emergency pre-emption.
// Lamps are registered from the next state so they change on the same edge as the FSM.
module adaptive_phase_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int CNT_W        = 3,
  parameter int TIME_W       = 6,
  parameter int MIN_GREEN    = 5,
  parameter int GREEN_STEP   = 2,
  parameter int MAX_GREEN    = 30,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int PED_TIME     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sec_tick,
  input  logic [NUM_PHASES*CNT_W-1:0]   demand,
  input  logic                          ped_req,
  input  logic [NUM_PHASES-1:0]         emerg,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic                          ped_walk,
  output logic [$clog2(NUM_PHASES)-1:0] cur_phase,
  output logic [TIME_W-1:0]             remaining,
  output state_t                        state_dbg
);

  localparam int PH_W = $clog2(NUM_PHASES);

  // Handshake-free block: every input is sampled on each clk edge; sec_tick qualifies timing only.
  state_t              state, state_n;
  logic [PH_W-1:0]     cur_n, pick, tgt, e_idx;
  logic [CNT_W-1:0]    tgt_cnt;
  logic [TIME_W-1:0]   green_dur, load_val;
  logic [NUM_PHASES-1:0] busy, lamp_mask;
  logic                e_any, load, done;
  logic                ped_pending, after_walk, fresh;
  logic                ped_clr, ped_set, walk_exit, served;

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      busy[i] = |demand[i*CNT_W +: CNT_W];
    end
  end

  assign e_any     = |emerg;
  assign e_idx     = PH_W'(lowest_set(32'(emerg)));
  assign pick      = PH_W'(next_phase(32'(cur_phase), 32'(busy), NUM_PHASES));
  // The first green after reset is phase 0 regardless of where the search would land.
  assign tgt       = fresh ? '0 : pick;
  assign tgt_cnt   = demand[tgt*CNT_W +: CNT_W];
  assign green_dur = TIME_W'(sat_green(32'(tgt_cnt), MIN_GREEN, GREEN_STEP, MAX_GREEN));

  always_comb begin
    state_n   = state;
    cur_n     = cur_phase;
    load      = 1'b0;
    load_val  = '0;
    ped_clr   = 1'b0;
    ped_set   = 1'b0;
    walk_exit = 1'b0;
    served    = 1'b0;
    case (state)
      ST_INIT: begin
        state_n  = ST_ALL_RED;
        load     = 1'b1;
        load_val = TIME_W'(ALL_RED_TIME);
      end
      ST_GREEN: begin
        if (e_any && e_idx == cur_phase) begin
          state_n = ST_EMERG_GREEN;
          load    = 1'b1;
        end else if (e_any || done) begin
          state_n  = ST_YELLOW;
          load     = 1'b1;
          load_val = TIME_W'(YELLOW_TIME);
        end
      end
      ST_YELLOW: begin
        if (done) begin
          state_n  = ST_ALL_RED;
          load     = 1'b1;
          load_val = TIME_W'(ALL_RED_TIME);
        end
      end
      ST_ALL_RED: begin
        if (done) begin
          load = 1'b1;
          if (e_any) begin
            state_n = ST_EMERG_GREEN;
            cur_n   = e_idx;
            served  = 1'b1;
          end else if (ped_pending && !after_walk && !fresh && tgt <= cur_phase) begin
            state_n  = ST_PED_WALK;
            load_val = TIME_W'(PED_TIME);
            ped_clr  = 1'b1;
          end else begin
            state_n  = ST_GREEN;
            cur_n    = tgt;
            load_val = green_dur;
            served   = 1'b1;
          end
        end
      end
      ST_PED_WALK: begin
        // An aborted walk is re-queued so it is served on a later wrap.
        if (e_any || done) begin
          state_n   = ST_ALL_RED;
          load      = 1'b1;
          load_val  = TIME_W'(ALL_RED_TIME);
          walk_exit = 1'b1;
          ped_set   = e_any;
        end
      end
      ST_EMERG_GREEN: begin
        if (!emerg[cur_phase]) begin
          state_n  = ST_YELLOW;
          load     = 1'b1;
          load_val = TIME_W'(YELLOW_TIME);
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  assign lamp_mask = {{(NUM_PHASES-1){1'b0}}, 1'b1} << cur_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      cur_phase   <= '0;
      ped_pending <= 1'b0;
      after_walk  <= 1'b0;
      fresh       <= 1'b1;
      green       <= '0;
      yellow      <= '0;
      red         <= '1;
      ped_walk    <= 1'b0;
    end else begin
      state     <= state_n;
      cur_phase <= cur_n;
      if (ped_clr) ped_pending <= 1'b0;
      else if (ped_set || ped_req) ped_pending <= 1'b1;
      if (served) after_walk <= 1'b0;
      else if (walk_exit) after_walk <= 1'b1;
      if (served) fresh <= 1'b0;
      green    <= (lamp_of(state_n) == LAMP_GREEN)  ? lamp_mask : '0;
      yellow   <= (lamp_of(state_n) == LAMP_YELLOW) ? lamp_mask : '0;
      red      <= (lamp_of(state_n) == LAMP_RED)    ? '1 : ~lamp_mask;
      ped_walk <= (state_n == ST_PED_WALK);
    end
  end

  phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (sec_tick),
    .count    (remaining),
    .done     (done)
  );

  assign state_dbg = state;

  lamp_invariant: assert property (@(posedge clk) disable iff (rst)
    $onehot0({green, yellow}) && !((|green) && ped_walk));

endmodule

// File: tb/tb_adaptive_phase_controller.sv
// Bench for adaptive_phase_controller: behavioural schedule model with per-cycle scoreboard,
// directed scenarios with literal expectations, then a randomized soak.
module tb_adaptive_phase_controller;

  localparam int N      = 4;
  localparam int CNT_W  = 3;
  localparam int TIME_W = 6;
  localparam int PH_W   = 2;
  localparam int W      = 3 * N + 1 + PH_W + TIME_W;
  localparam int MIN_G = 5, STEP = 2, MAX_G = 30, YEL = 3, AR = 1, PED = 10;

  logic clk, rst, rst2, sec_tick, ped_req, ped_req2;
  logic [N*CNT_W-1:0] demand, demand2;
  logic [N-1:0] emerg, emerg2;
  logic [N-1:0] green, yellow, red, g2, y2, r2;
  logic ped_walk, w2;
  logic [PH_W-1:0] cur_phase, cp2;
  logic [TIME_W-1:0] remaining, rem2;
  logic [2:0] st_dbg, st2;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  adaptive_phase_controller dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .demand(demand), .ped_req(ped_req),
    .emerg(emerg), .green(green), .yellow(yellow), .red(red), .ped_walk(ped_walk),
    .cur_phase(cur_phase), .remaining(remaining), .state_dbg(st_dbg)
  );

  adaptive_phase_controller #(.MIN_GREEN(20)) dut_sat (
    .clk(clk), .rst(rst2), .sec_tick(sec_tick), .demand(demand2), .ped_req(ped_req2),
    .emerg(emerg2), .green(g2), .yellow(y2), .red(r2), .ped_walk(w2),
    .cur_phase(cp2), .remaining(rem2), .state_dbg(st2)
  );

  // ---------------- behavioural model ----------------
  typedef enum {S_BOOT, S_GO, S_AMBER, S_CLEAR, S_WALK, S_PRIORITY} seg_e;
  seg_e seg;
  int left, ph, mped, maw, mfresh;
  bit model_on = 0;

  function automatic bit bit_at(logic [N-1:0] v, int p);
    return ((v >> p) & N'(1)) != '0;
  endfunction

  function automatic int demand_of(int p);
    return int'((demand >> (p * CNT_W)) & {{(N*CNT_W-CNT_W){1'b0}}, {CNT_W{1'b1}}});
  endfunction

  function automatic int green_len(int d);
    int v = MIN_G + d * STEP;
    return (v > MAX_G) ? MAX_G : v;
  endfunction

  function automatic int pick(int cur);
    for (int k = 1; k <= N; k++) begin
      if (demand_of((cur + k) % N) != 0) return (cur + k) % N;
    end
    return (cur + 1) % N;
  endfunction

  function automatic int first_emerg();
    for (int i = 0; i < N; i++) if (bit_at(emerg, i)) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      seg = S_BOOT; left = 0; ph = 0; mped = 0; maw = 0; mfresh = 1; model_on = 1;
    end else if (model_on) begin
      int e, nxt, nleft;
      bit expire, clr, setp;
      seg_e nseg;
      e = first_emerg();
      expire = sec_tick && left == 1;
      clr = 0; setp = 0;
      nseg = seg;
      nleft = (sec_tick && left > 0) ? left - 1 : left;
      case (seg)
        S_BOOT: begin nseg = S_CLEAR; nleft = AR; end
        S_GO:
          if (e == ph) begin nseg = S_PRIORITY; nleft = 0; end
          else if (e >= 0 || expire) begin nseg = S_AMBER; nleft = YEL; end
        S_AMBER: if (expire) begin nseg = S_CLEAR; nleft = AR; end
        S_CLEAR:
          if (expire) begin
            if (e >= 0) begin
              nseg = S_PRIORITY; ph = e; nleft = 0; maw = 0; mfresh = 0;
            end else begin
              nxt = mfresh ? 0 : pick(ph);
              if (!mfresh && mped != 0 && maw == 0 && nxt <= ph) begin
                nseg = S_WALK; nleft = PED; clr = 1;
              end else begin
                nseg = S_GO; ph = nxt; nleft = green_len(demand_of(nxt)); maw = 0; mfresh = 0;
              end
            end
          end
        S_WALK:
          if (e >= 0 || expire) begin
            nseg = S_CLEAR; nleft = AR; maw = 1; setp = (e >= 0);
          end
        S_PRIORITY: if (!bit_at(emerg, ph)) begin nseg = S_AMBER; nleft = YEL; end
        default: nseg = S_BOOT;
      endcase
      if (clr) mped = 0;
      else if (setp || ped_req) mped = 1;
      seg = nseg;
      left = nleft;
    end
    if (model_on) begin
      logic [N-1:0] g, y;
      g = (seg == S_GO || seg == S_PRIORITY) ? (N'(1) << ph) : '0;
      y = (seg == S_AMBER) ? (N'(1) << ph) : '0;
      exp_q.push_back({g, y, ~(g | y), (seg == S_WALK), PH_W'(ph), TIME_W'(left)});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] ev, av;
      ev = exp_q.pop_front();
      av = {green, yellow, red, ped_walk, cur_phase, remaining};
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL model t=%0t: got g=%b y=%b r=%b w=%b cur=%0d rem=%0d want g=%b y=%b r=%b w=%b cur=%0d rem=%0d",
                 $time, av[20:17], av[16:13], av[12:9], av[8], av[7:6], av[5:0],
                 ev[20:17], ev[16:13], ev[12:9], ev[8], ev[7:6], ev[5:0]);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic wait_green(input int p, input string nm, output logic [N-1:0] others,
                            output int walks);
    int n = 0;
    others = '0; walks = 0;
    while (!bit_at(green, p) && n < 400) begin
      others |= green;
      walks += int'(ped_walk);
      @(negedge clk);
      n++;
    end
    check(nm, int'(bit_at(green, p)), 1);
  endtask

  task automatic wait_walk(input string nm);
    int n = 0;
    while (!ped_walk && n < 400) begin @(negedge clk); n++; end
    check(nm, int'(ped_walk), 1);
  endtask

  // kind 0: green[p], 1: yellow[p], 2: walk, 3: all-red clearance
  function automatic bit sig(int kind, int p);
    case (kind)
      0: return bit_at(green, p);
      1: return bit_at(yellow, p);
      2: return ped_walk;
      default: return (red == '1) && !ped_walk;
    endcase
  endfunction

  task automatic run_len(input int kind, input int p, output int n);
    n = 0;
    while (sig(kind, p) && n < 200) begin n++; @(negedge clk); end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] oth;
    int wk, n, ok, hold;
    rst = 1; rst2 = 1; sec_tick = 1; ped_req = 0; ped_req2 = 0;
    demand = 12'h1C2;          // d0=2, d1=0, d2=7, d3=0
    demand2 = 12'hFFF; emerg = '0; emerg2 = '0;
    repeat (3) @(negedge clk);
    check("reset_red", int'(red), 15);
    check("reset_green", int'(green), 0);
    check("reset_rem", int'(remaining), 0);
    rst = 0; rst2 = 0;

    // green saturation at MAX_GREEN with MIN_GREEN=20
    n = 0;
    while (!g2[0] && n < 50) begin @(negedge clk); n++; end
    check("sat_green_seen", int'(g2[0]), 1);
    check("sat_start", int'(rem2), 30);
    ok = 1;
    for (int i = 30; i >= 1; i--) begin
      if (rem2 != TIME_W'(i) || !g2[0]) ok = 0;
      @(negedge clk);
    end
    check("sat_countdown", ok, 1);
    check("sat_yellow", int'(y2[0]), 1);

    // reset mid-green together with a tick
    wait_green(0, "t1_pre", oth, wk);
    repeat (3) @(negedge clk);
    rst = 1; sec_tick = 1;
    @(negedge clk);
    rst = 0;
    check("t1_red", int'(red), 15);
    check("t1_green", int'(green), 0);
    check("t1_rem", int'(remaining), 0);

    // demand-sized greens with skipping
    wait_green(0, "t2_first", oth, wk);
    check("t2_first_no_other", int'(oth), 0);
    run_len(0, 0, n); check("t2_green0_len", n, 9);
    wait_green(2, "t2_phase2", oth, wk);
    check("t2_skip1", int'(oth), 0);
    run_len(0, 2, n); check("t2_green2_len", n, 19);
    run_len(1, 2, n); check("t2_yellow_len", n, 3);
    run_len(3, 0, n); check("t2_allred_len", n, 1);
    check("t2_wrap", int'(green), 1);

    // ped walk at the wrap, second press during walk
    wait_green(2, "t4_g2", oth, wk);
    ped_req = 1; @(negedge clk); ped_req = 0;
    wait_walk("t4_walk_seen");
    n = 0; oth = '0;
    for (int i = 0; i < 10; i++) begin
      n += int'(ped_walk); oth |= green;
      if (i == 4) ped_req = 1;
      @(negedge clk);
      ped_req = 0;
    end
    check("t4_walk_len", n, 10);
    check("t4_walk_end", int'(ped_walk), 0);
    check("t4_no_green_in_walk", int'(oth), 0);
    wait_green(0, "t4_g0", oth, wk); check("t4_no_rewalk_yet", wk, 0);
    wait_green(2, "t4_g2b", oth, wk); check("t4_no_walk_midcycle", wk, 0);
    wait_green(0, "t4_g0b", oth, wk); check("t4_second_walk", wk, 10);
    wait_green(2, "t4_g2c", oth, wk);
    wait_green(0, "t4_g0c", oth, wk); check("t4_no_third_walk", wk, 0);

    // emergency on phase 1 during phase 0 green
    repeat (2) @(negedge clk);
    emerg = 4'b1010;
    @(negedge clk);
    check("t5_yellow_next", int'(yellow), 1);
    run_len(1, 0, n); check("t5_yellow_len", n, 3);
    run_len(3, 0, n); check("t5_allred_len", n, 1);
    check("t5_emerg_green", int'(green), 2);
    check("t5_emerg_rem", int'(remaining), 0);
    hold = 0;
    for (int i = 0; i < 20; i++) begin hold += int'(green == 4'b0010); @(negedge clk); end
    check("t5_hold", hold, 20);
    emerg = '0;
    @(negedge clk);
    check("t5_release_yellow", int'(yellow), 2);
    run_len(1, 1, n); check("t5_rel_yellow_len", n, 3);
    run_len(3, 0, n); check("t5_rel_allred_len", n, 1);
    check("t5_next_phase2", int'(green), 4);

    // emergency on phase 2 aborts a walk
    ped_req = 1; @(negedge clk); ped_req = 0;
    wait_walk("t6_walk_seen");
    repeat (3) @(negedge clk);
    emerg = 4'b0100;
    @(negedge clk);
    check("t6_walk_drop", int'(ped_walk), 0);
    check("t6_allred", int'(red), 15);
    run_len(3, 0, n); check("t6_allred_len", n, 1);
    check("t6_emerg_green", int'(green), 4);
    repeat (5) @(negedge clk);
    emerg = '0;
    wait_green(0, "t6_g0", oth, wk); check("t6_walk_reserved", wk, 10);

    // randomized soak against the model
    hold = 0;
    for (int c = 0; c < 6000; c++) begin
      sec_tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) demand = 12'($urandom);
      ped_req = ($urandom_range(0, 59) == 0);
      if (hold > 0) hold--;
      else if (emerg != '0) emerg = '0;
      else if ($urandom_range(0, 149) == 0) begin
        emerg = 4'($urandom_range(1, 15));
        hold = $urandom_range(1, 40);
      end
      rst = ($urandom_range(0, 1999) == 0);
      @(negedge clk);
    end
    rst = 0; emerg = '0; ped_req = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
